root_5_en_multi_cycle: RTL and testbench
========================================

ROOT_5_EN_MULTI_CYCLE -- requirements
Module: root_5_en_multi_cycle

Interface
REQ-001 Parameter w, default 8: argument width in bits.
REQ-002 Derived constant rw = (w+4)/5: significant result bits; res bits [w-1:rw] SHALL be zero.
REQ-003 clk  input  1: single clock, all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 clk_en  input  1: global enable; when low, all state and outputs SHALL hold.
REQ-006 arg_vld  input  1: argument strobe.
REQ-007 arg  input  w: unsigned argument.
REQ-008 busy  output  1: high while a computation is in progress; the block is ready when low.
REQ-009 res_vld  output  1: one-enabled-cycle result strobe.
REQ-010 res  output  w: floor(arg^(1/5)), unsigned.

Function
REQ-011 The block SHALL accept arg on an edge where clk_en=1, arg_vld=1, busy=0; arg_vld while busy=1 SHALL be ignored with no side effect.
REQ-012 The block SHALL use FSM states IDLE, LOAD, MUL, CMP, with busy = (state != IDLE).
REQ-013 Transitions: IDLE->LOAD on accept; LOAD->MUL; MUL->MUL for 4 cycles then ->CMP; CMP->LOAD if bits remain, else ->IDLE.
REQ-014 Search SHALL be bitwise MSB-first over bit index i = rw-1 down to 0; the partial root starts at 0 on accept.
REQ-015 In LOAD: cand = root | (1<<i), p = cand.
REQ-016 In each MUL cycle: p = p * cand.
REQ-017 In CMP: root = cand if p <= arg, else root unchanged; then i decrements.
REQ-018 p SHALL be 5*rw bits wide, arg zero-extended for comparison, and no truncation SHALL be permitted.
REQ-019 Latency: res_vld and res SHALL be valid exactly 6*rw enabled cycles after the accept edge (12 for w=8).
REQ-020 res_vld SHALL be high for exactly one enabled cycle; res SHALL hold its last value until the next result.
REQ-021 A new accept SHALL be permitted in the same cycle res_vld is high (back-to-back operation).
REQ-022 Disabled cycles (clk_en=0) SHALL NOT count toward latency; res_vld SHALL stay high through them until the next enabled edge.

Reset
REQ-023 On rst=1 at an edge: state=IDLE, busy=0, res_vld=0, res=0, root=0; any in-flight computation SHALL be abandoned.
REQ-024 rst SHALL take priority over clk_en.
REQ-025 Working registers p, cand, and i may be left without reset; they SHALL NOT affect outputs before the next accept.

Configuration
REQ-026 Macro ROOT5_ARG_REG_EN:
- Defined: arg_vld and arg SHALL be registered (with clk_en) before acceptance logic; latency becomes 6*rw+1 and busy is asserted one cycle later.
- An input captured in the register while busy SHALL be dropped.
- Undefined: direct acceptance, as specified above.

Structure
REQ-027 Package root5_pkg SHALL hold:
- FSM state encodings (IDLE, LOAD, MUL, CMP);
- MUL cycle count constant (4);
- function computing rw from w.
REQ-028 A single sub-module reg_rst_en (parameterised width, synchronous active-high reset, enable) SHALL implement state, root, res, and res_vld registers.

Verification
REQ-029 w=8 sweep arg=0..255 -> res equals floor fifth root, e.g. 0->0, 1->1, 31->1, 32->2, 242->2, 243->3, 255->3.
REQ-030 w=8: accept arg=243 -> busy high for 12 enabled cycles; res_vld single pulse with res=3 at cycle 12.
REQ-031 arg=100 while busy during computation of arg=243 -> result 3 only; no second res_vld.
REQ-032 clk_en toggled randomly (50%) during arg=32 -> res=2 after exactly 12 enabled cycles; res_vld held across disabled cycles.
REQ-033 rst asserted in MUL of the second bit -> next cycle busy=0, res_vld=0, res=0; a subsequent arg=1 yields res=1.
REQ-034 Back-to-back: new accept in res_vld cycle, 243 then 31 -> results 3 then 1, 12 cycles apart.

Source files
------------

// File: rtl/root5_pkg.sv
// root5_pkg
//   Shared definitions for the fifth-root calculator.
//   - FSM state encodings (IDLE must stay all-zero: the state register
//     clears to zero on reset).
//   - Number of multiply cycles per candidate bit.
//   - calcRw(): number of significant result bits for a given argument width.
package root5_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_MUL  = 2'd2;
  localparam state_t S_CMP  = 2'd3;

  // Four multiplies turn p = cand into p = cand^5.
  localparam int MUL_CYCLES = 4;

  // floor(arg^(1/5)) of a w-bit number fits in ceil(w/5) bits.
  function automatic int calcRw(input int w);
    return (w + 4) / 5;
  endfunction

endpackage

// File: rtl/root_5_en_multi_cycle_if.sv
// root_5_en_multi_cycle_if
//   Handshake bundle of the fifth-root calculator.
//   Parameter: w - argument / result width.
//   Signals:
//     clk_en   global enable (everything holds while low)
//     arg_vld  argument strobe
//     arg      unsigned argument, w bits
//     busy     computation in progress
//     res_vld  one-enabled-cycle result strobe
//     res      floor fifth root, w bits (upper bits zero)
//   Modports: master drives requests and observes results, slave is the
//   calculator itself.
interface root_5_en_multi_cycle_if #(
  parameter int w = 8
);

  logic         clk_en;
  logic         arg_vld;
  logic [w-1:0] arg;
  logic         busy;
  logic         res_vld;
  logic [w-1:0] res;

  modport master (
    output clk_en,
    output arg_vld,
    output arg,
    input  busy,
    input  res_vld,
    input  res
  );

  modport slave (
    input  clk_en,
    input  arg_vld,
    input  arg,
    output busy,
    output res_vld,
    output res
  );

endinterface

// File: rtl/reg_rst_en.sv
// reg_rst_en
//   Generic register with synchronous active-high reset to zero and a
//   load enable. Reset wins over the enable.
//   Ports:
//     clk   clock
//     rst   synchronous reset, active high
//     en_i  load enable
//     d_i   next value, width bits
//     q_o   registered value, width bits
module reg_rst_en #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  // Reset first so a reset edge clears the register even while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/root_5_en_multi_cycle.sv
// root_5_en_multi_cycle
//   Multi-cycle floor fifth root. The root is searched MSB first: for each
//   bit the candidate root|bit is raised to the fifth power with four
//   sequential multiplies and kept if the power does not exceed the
//   argument. Each bit takes LOAD + 4*MUL + CMP = 6 enabled cycles.
//   Ports:
//     clk  clock, rising edge
//     rst  synchronous reset, active high, has priority over clk_en
//     bus  root_5_en_multi_cycle_if.slave (clk_en, arg_vld, arg, busy,
//          res_vld, res)
//   Parameter: w - argument width (default 8).
//   Build option: define ROOT5_ARG_REG_EN to register arg_vld/arg before
//   the acceptance logic; this adds one cycle of latency and busy rises
//   one cycle after the input edge.
module root_5_en_multi_cycle
  import root5_pkg::*;
#(
  parameter int w = 8
) (
  input logic                    clk,
  input logic                    rst,
  root_5_en_multi_cycle_if.slave bus
);

  localparam int rw = calcRw(w);
  localparam int pw = 5 * rw;
  localparam int iw = $clog2(rw + 1);
  localparam int cw = $clog2(MUL_CYCLES + 1);

  logic          acceptVld;
  logic [w-1:0]  acceptArg;
  logic          accept;

  state_t        stateQ, stateD;
  logic [rw-1:0] rootQ, rootD;
  logic [w-1:0]  resQ, resD;
  logic          resVldQ, resVldD;

  logic [rw-1:0] candQ;
  logic [rw-1:0] candLoad;
  logic [rw-1:0] rootCmp;
  logic [pw-1:0] prodQ;
  logic [pw-1:0] argExt;
  logic [w-1:0]  argQ;
  logic [iw-1:0] bitIdxQ;
  logic [cw-1:0] mulCntQ;

`ifdef ROOT5_ARG_REG_EN
  logic          argVldRegQ;
  logic [w-1:0]  argRegQ;

  // Input stage: the strobe is reset so a stale request cannot survive a
  // reset; the data needs no reset. Anything captured here while busy is
  // simply overwritten next cycle, which drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      argVldRegQ <= 1'b0;
    end else if (bus.clk_en) begin
      argVldRegQ <= bus.arg_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.clk_en) begin
      argRegQ <= bus.arg;
    end
  end

  assign acceptVld = argVldRegQ;
  assign acceptArg = argRegQ;
`else
  assign acceptVld = bus.arg_vld;
  assign acceptArg = bus.arg;
`endif

  // Requests are only taken while idle; a strobe during a computation
  // touches nothing.
  assign accept   = (stateQ == S_IDLE) && acceptVld;

  // Candidate for the bit under test, and the root after comparing its
  // fifth power against the (zero-extended) argument.
  assign candLoad = rootQ | (rw'(1) << bitIdxQ);
  assign argExt   = pw'(argQ);
  assign rootCmp  = (prodQ <= argExt) ? candQ : rootQ;

  // Control: next state, partial root and result registers.
  always_comb begin
    stateD  = stateQ;
    rootD   = rootQ;
    resD    = resQ;
    resVldD = 1'b0;
    case (stateQ)
      S_IDLE: begin
        if (accept) begin
          stateD = S_LOAD;
          rootD  = '0;
        end
      end
      S_LOAD: begin
        stateD = S_MUL;
      end
      S_MUL: begin
        if (mulCntQ == cw'(MUL_CYCLES - 1)) begin
          stateD = S_CMP;
        end
      end
      S_CMP: begin
        rootD = rootCmp;
        if (bitIdxQ == '0) begin
          stateD  = S_IDLE;
          resD    = w'(rootCmp);
          resVldD = 1'b1;
        end else begin
          stateD = S_LOAD;
        end
      end
      default: begin
        stateD = S_IDLE;
      end
    endcase
  end

  // Datapath working registers. They are initialised on accept/LOAD before
  // being read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (bus.clk_en) begin
      case (stateQ)
        S_IDLE: begin
          if (accept) begin
            argQ    <= acceptArg;
            bitIdxQ <= iw'(rw - 1);
          end
        end
        S_LOAD: begin
          candQ   <= candLoad;
          prodQ   <= pw'(candLoad);
          mulCntQ <= '0;
        end
        S_MUL: begin
          prodQ   <= prodQ * pw'(candQ);
          mulCntQ <= mulCntQ + cw'(1);
        end
        S_CMP: begin
          bitIdxQ <= bitIdxQ - iw'(1);
        end
        default: begin
        end
      endcase
    end
  end

  reg_rst_en #(.width($bits(state_t))) stateReg (
    .clk (clk),
    .rst (rst),
    .en_i(bus.clk_en),
    .d_i (stateD),
    .q_o (stateQ)
  );

  reg_rst_en #(.width(rw)) rootReg (
    .clk (clk),
    .rst (rst),
    .en_i(bus.clk_en),
    .d_i (rootD),
    .q_o (rootQ)
  );

  reg_rst_en #(.width(w)) resReg (
    .clk (clk),
    .rst (rst),
    .en_i(bus.clk_en),
    .d_i (resD),
    .q_o (resQ)
  );

  // The strobe register is enabled like the rest, so a pulse stretches
  // across disabled cycles and drops at the next enabled edge.
  reg_rst_en #(.width(1)) resVldReg (
    .clk (clk),
    .rst (rst),
    .en_i(bus.clk_en),
    .d_i (resVldD),
    .q_o (resVldQ)
  );

  assign bus.busy    = (stateQ != S_IDLE);
  assign bus.res_vld = resVldQ;
  assign bus.res     = resQ;

endmodule

// File: tb/tb_root_5_en_multi_cycle.sv
// tb_root_5_en_multi_cycle
//   Scoreboard bench for the fifth-root calculator (w = 8). Accepted
//   requests push {expected root, accept count, due count} where counts are
//   in enabled clock edges; a negedge monitor checks busy/res_vld/res on
//   every enabled cycle and res_vld hold on every disabled cycle.
module tb_root_5_en_multi_cycle;

  localparam int W  = 8;
  localparam int RW = (W + 4) / 5;
`ifdef ROOT5_ARG_REG_EN
  localparam int ARG_DLY = 1;
`else
  localparam int ARG_DLY = 0;
`endif
  localparam int LAT = 6 * RW + ARG_DLY;

  typedef struct {
    logic [W-1:0] arg;
    logic [W-1:0] expRes;
    int           accCnt;
    int           dueCnt;
  } entry_t;

  logic   clk = 1'b0;
  logic   rst;
  entry_t scoreQ[$];
  int     enCnt = 0;
  bit     lastEdgeEn = 1'b0;
  bit     monitorOn = 1'b0;
  bit     randEn = 1'b0;
  bit     prevExpVld = 1'b0;
  logic [W-1:0] lastRes = '0;
  int     checks = 0;
  int     passes = 0;
  int     fails = 0;

  root_5_en_multi_cycle_if #(.w(W)) bus ();

  root_5_en_multi_cycle #(.w(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: largest r with r^5 <= a.
  function automatic logic [W-1:0] fifthRoot(input int a);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) * (r + 1) * (r + 1) <= longint'(a)) r++;
    return W'(r);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count enabled, non-reset edges; the bench drives clk_en/rst itself.
  always @(posedge clk) begin
    lastEdgeEn = (bus.clk_en === 1'b1) && (rst === 1'b0);
    if (lastEdgeEn) enCnt++;
  end

  // clk_en is either held high or randomised at 50% per cycle.
  initial begin
    bus.clk_en = 1'b1;
    forever begin
      @(negedge clk);
      bus.clk_en = randEn ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    bit expVld;
    bit expBusy;
    if (monitorOn) begin
      if (lastEdgeEn) begin
        expVld  = 1'b0;
        expBusy = 1'b0;
        if (scoreQ.size() > 0) begin
          expVld  = (enCnt == scoreQ[0].dueCnt);
          expBusy = (enCnt >= scoreQ[0].accCnt + ARG_DLY) && (enCnt < scoreQ[0].dueCnt);
        end
        checkOutput("res_vld", 32'(bus.res_vld), 32'(expVld));
        checkOutput("busy", 32'(bus.busy), 32'(expBusy));
        if (expVld) begin
          checkOutput("res", 32'(bus.res), 32'(scoreQ[0].expRes));
          lastRes = scoreQ[0].expRes;
          void'(scoreQ.pop_front());
        end else begin
          checkOutput("res_hold", 32'(bus.res), 32'(lastRes));
        end
        prevExpVld = expVld;
      end else begin
        checkOutput("res_vld_hold", 32'(bus.res_vld), 32'(prevExpVld));
      end
    end
  end

  // Called just after a negedge: present the request until an enabled edge
  // takes it, then drop the strobe at the following negedge.
  task automatic applyStimulus(input logic [W-1:0] a, input bit expectAccept);
    int n;
    entry_t e;
    n = 0;
    bus.arg     = a;
    bus.arg_vld = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!lastEdgeEn && n < 200);
    checkOutput("accept_edge", 32'(lastEdgeEn), 32'd1);
    if (expectAccept) begin
      e.arg    = a;
      e.expRes = fifthRoot(int'(a));
      e.accCnt = enCnt;
      e.dueCnt = enCnt + LAT;
      scoreQ.push_back(e);
    end
    @(negedge clk);
    bus.arg_vld = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    while (scoreQ.size() > 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_results", 32'(scoreQ.size()), 32'd0);
    scoreQ.delete();
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    bus.arg_vld = 1'b0;
    bus.arg     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_res_vld", 32'(bus.res_vld), 32'd0);
    checkOutput("reset_res", 32'(bus.res), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    monitorOn = 1'b1;

    $display("[TB] sweep 0..255");
    for (int a = 0; a < 256; a++) begin
      applyStimulus(W'(a), 1'b1);
      waitDone(100);
    end

    $display("[TB] strobe while busy is ignored");
    applyStimulus(8'd243, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(8'd100, 1'b0);
    waitDone(100);
    repeat (20) @(negedge clk);

    $display("[TB] random clk_en");
    randEn = 1'b1;
    applyStimulus(8'd32, 1'b1);
    waitDone(400);
    randEn = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset during second bit");
    applyStimulus(8'd255, 1'b1);
    repeat (7) @(negedge clk);
    monitorOn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_res_vld", 32'(bus.res_vld), 32'd0);
    checkOutput("midreset_res", 32'(bus.res), 32'd0);
    scoreQ.delete();
    lastRes    = '0;
    prevExpVld = 1'b0;
    rst        = 1'b0;
    monitorOn  = 1'b1;
    @(negedge clk);
    applyStimulus(8'd1, 1'b1);
    waitDone(100);

    $display("[TB] back-to-back");
    applyStimulus(8'd243, 1'b1);
    n = 0;
    while (bus.res_vld !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_first_result", 32'(bus.res_vld), 32'd1);
    applyStimulus(8'd31, 1'b1);
    waitDone(100);
    repeat (5) @(negedge clk);

    monitorOn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
